// File: rtl/mem_responder_bram.sv
// mem_responder_bram: on-chip RAM responder with fixed-latency in-order read pipeline and write ack
module mem_responder_bram #(
  parameter int MEMADDR_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH_LOG2    = 10,
  parameter int READ_LATENCY  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [MEMADDR_WIDTH-1:0] read_address,
  input  logic                     read_address_valid,
  output logic [DATA_WIDTH-1:0]    read_data,
  output logic                     read_data_valid,
  input  logic [MEMADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0]    write_data,
  input  logic                     write_valid,
  output logic                     write_ack
);
  if (READ_LATENCY < 1 || READ_LATENCY > 8) begin : g_bad_latency
    $error("READ_LATENCY must be within 1..8");
  end
  logic [DATA_WIDTH-1:0]   ram [1 << DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0]   ridx, widx;
  logic [DATA_WIDTH-1:0]   rword;
  logic [READ_LATENCY-1:0] pv;
  logic [DATA_WIDTH-1:0]   pd [READ_LATENCY];
  logic                    unused_addr_bits;
  assign ridx = read_address[DEPTH_LOG2-1:0];
  assign widx = write_address[DEPTH_LOG2-1:0];
  assign unused_addr_bits = ^{read_address[MEMADDR_WIDTH-1:DEPTH_LOG2], write_address[MEMADDR_WIDTH-1:DEPTH_LOG2]};
  // Same-index collision is write-first: forward the incoming word.
  always_comb rword = (write_valid && widx == ridx) ? write_data : ram[ridx];
  always_ff @(posedge clk)
    if (write_valid) ram[widx] <= write_data;
  // Data stages only load behind a valid so the output holds the last response.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pv        <= '0;
      write_ack <= 1'b0;
      for (int i = 0; i < READ_LATENCY; i++) pd[i] <= '0;
    end else begin
      write_ack <= write_valid;
      pv[0]     <= read_address_valid;
      if (read_address_valid) pd[0] <= rword;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        if (pv[i-1]) pd[i] <= pd[i-1];
      end
    end
  assign read_data_valid = pv[READ_LATENCY-1];
  assign read_data       = pd[READ_LATENCY-1];
  a_no_x_valid: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown({read_address_valid, write_valid}));
endmodule

// File: tb/tb_mem_responder_bram.sv
// tb_mem_responder_bram: three responders (latency 1, 2, 8) share stimulus; a negedge monitor
// checks every cycle against per-instance queues of expected responses and their due cycles.
module tb_mem_responder_bram;
  typedef struct {
    logic [31:0] d;
    int          due;
  } rexp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] read_address = '0;
  logic        read_address_valid = 1'b0;
  logic [31:0] write_address = '0;
  logic [31:0] write_data = '0;
  logic        write_valid = 1'b0;
  logic [31:0] rdata [3];
  logic        rvalid [3];
  logic        wack [3];
  int          lat [3] = '{1, 2, 8};
  int          cyc = 0;
  int          total = 0;
  int          passed = 0;
  rexp_t       rq [3][$];
  int          wq [3][$];
  rexp_t       mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder_bram #(.READ_LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .read_address(read_address), .read_address_valid(read_address_valid),
    .read_data(rdata[0]), .read_data_valid(rvalid[0]), .write_address(write_address),
    .write_data(write_data), .write_valid(write_valid), .write_ack(wack[0]));
  mem_responder_bram #(.READ_LATENCY(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .read_address(read_address), .read_address_valid(read_address_valid),
    .read_data(rdata[1]), .read_data_valid(rvalid[1]), .write_address(write_address),
    .write_data(write_data), .write_valid(write_valid), .write_ack(wack[1]));
  mem_responder_bram #(.READ_LATENCY(8)) u_l8 (
    .clk(clk), .rst_n(rst_n), .read_address(read_address), .read_address_valid(read_address_valid),
    .read_data(rdata[2]), .read_data_valid(rvalid[2]), .write_address(write_address),
    .write_data(write_data), .write_valid(write_valid), .write_ack(wack[2]));

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s lat=%0d cyc=%0d: got %h expected %h", name, lat[k], cyc, act, exp);
  endtask

  // A response is due exactly at its recorded cycle; every other cycle must be idle.
  always @(negedge clk)
    if (rst_n)
      for (int k = 0; k < 3; k++) begin
        if (rq[k].size() > 0 && rq[k][0].due == cyc) begin
          mon_e = rq[k].pop_front();
          chk("rd_valid", k, 32'(rvalid[k]), 32'd1);
          chk("rd_data", k, rdata[k], mon_e.d);
        end else chk("rd_idle", k, 32'(rvalid[k]), 32'd0);
        if (wq[k].size() > 0 && wq[k][0] == cyc) begin
          void'(wq[k].pop_front());
          chk("wr_ack", k, 32'(wack[k]), 32'd1);
        end else chk("wr_idle", k, 32'(wack[k]), 32'd0);
      end

  task automatic drive(input logic rv, input logic [31:0] ra, input logic [31:0] rexp,
                       input logic wv, input logic [31:0] wa, input logic [31:0] wd);
    @(negedge clk);
    read_address_valid = rv;
    read_address       = ra;
    write_valid        = wv;
    write_address      = wa;
    write_data         = wd;
    for (int k = 0; k < 3; k++) begin
      if (rv) rq[k].push_back('{rexp, cyc + lat[k]});
      if (wv) wq[k].push_back(cyc + 1);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    drive(1'b0, '0, '0, 1'b1, a, d);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e);
    drive(1'b1, a, e, 1'b0, '0, '0);
  endtask

  task automatic check_outputs_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_rvalid"}, k, 32'(rvalid[k]), 32'd0);
      chk({tag, "_wack"}, k, 32'(wack[k]), 32'd0);
      chk({tag, "_rdata"}, k, rdata[k], 32'd0);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1 check_outputs_zero("reset");
    @(negedge clk);
    #2 rst_n = 1'b1;
    // single write then read
    wr(32'h5, 32'hDEADBEEF);
    idle(2);
    rd(32'h5, 32'hDEADBEEF);
    idle(10);
    // streaming: back-to-back writes then back-to-back reads
    for (int i = 0; i < 8; i++) wr(i, i * 3);
    for (int i = 0; i < 8; i++) rd(i, i * 3);
    idle(10);
    // same-cycle collision is write-first
    wr(32'h10, 32'hAAAA);
    drive(1'b1, 32'h10, 32'h1234, 1'b1, 32'h10, 32'h1234);
    // write one cycle after the read: in-flight read keeps the old word
    wr(32'h10, 32'hAAAA);
    rd(32'h10, 32'hAAAA);
    wr(32'h10, 32'h5555);
    rd(32'h10, 32'h5555);
    idle(10);
    // read and write to different indices in the same cycle
    drive(1'b1, 32'h5, 32'd15, 1'b1, 32'h20, 32'h99);
    rd(32'h20, 32'h99);
    idle(10);
    // aliasing on upper address bits
    wr(32'h0000_0405, 32'h77);
    rd(32'h5, 32'h77);
    rd(32'hFFFF_FC20, 32'h99);
    idle(10);
    // reset while reads are in flight: anything not yet delivered is dropped
    rd(32'h20, 32'h99);
    @(negedge clk);
    read_address_valid = 1'b0;
    #2 rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rq[k].delete();
      wq[k].delete();
    end
    #1 check_outputs_zero("midrst");
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check_outputs_zero("postrst");
    idle(12);
    for (int k = 0; k < 3; k++) begin
      chk("rq_drained", k, 32'(rq[k].size()), 32'd0);
      chk("wq_drained", k, 32'(wq[k].size()), 32'd0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_responder_bram.md
Name: mem_responder_bram

Overview:
- On-chip memory model implementing the responder side of the team's mem_interface protocol: answers reads and writes from any requester block (e.g. the AXI/SCAD bridge under test).
- Synchronous single-port-per-direction RAM array plus a fixed-latency, in-order read-response pipeline and a write-acknowledge register.
- No backpressure: one read and one write are accepted per cycle.

Parameters:
- MEMADDR_WIDTH, 32, width of read_address/write_address (word address).
- DATA_WIDTH, 32, data word width.
- DEPTH_LOG2, 10, log2 of array depth in words (1024 words).
- READ_LATENCY, 2, cycles from accepted read to read_data_valid; legal range 1..8, other values fail elaboration.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mem  interface  mem_interface.responder (MEMADDR_WIDTH, DATA_WIDTH)  bundle below.
- mem.read_address  input  MEMADDR_WIDTH  read word address.
- mem.read_address_valid  input  1  read request, one per high cycle.
- mem.read_data  output  DATA_WIDTH  read response data.
- mem.read_data_valid  output  1  read response strobe, one cycle per request.
- mem.write_address  input  MEMADDR_WIDTH  write word address.
- mem.write_data  input  DATA_WIDTH  write data.
- mem.write_valid  input  1  write request, one per high cycle.
- mem.write_ack  output  1  write completion strobe.

Behaviour:
- Reset (rst_n low, async): read_data_valid=0, read_data=0, write_ack=0, entire latency pipeline valid bits cleared. Array contents not reset (X in sim).
- Addressing: index = address[DEPTH_LOG2-1:0]. Upper bits ignored (aliasing, no error).
- Write: every cycle with write_valid=1 at a rising edge, array[index] <= write_data. write_ack=1 exactly one cycle later for exactly one cycle. Back-to-back writes give back-to-back acks.
- Read: every cycle with read_address_valid=1 is accepted. read_data_valid=1 with the data exactly READ_LATENCY cycles after the accept edge. One response per request, in order, fully pipelined (throughput 1/cycle).
- read_data: holds the last returned value while read_data_valid=0. Not zeroed between responses.
- Read and write in the same cycle to the same index: write-first. The read returns the new write_data.
- Read and write in the same cycle to different indices: both proceed independently.
- Write to an address with a read to that address already in flight (accepted in an earlier cycle): the in-flight read returns the old data. Data is sampled at the accept edge.
- Pipeline structure: shift register of READ_LATENCY stages {valid, data}. Stage 0 is loaded at the accept edge from the array or the write bypass.
- Reset mid-operation: all in-flight reads are discarded. No read_data_valid or write_ack appears after rst_n deasserts unless a new request arrives.
- Input X on a valid signal while rst_n=1: simulation assertion fires.

Test Plan:
- Single write/read: write addr 0x5 data 0xDEADBEEF -> write_ack high in cycle+1 only. Read addr 0x5 -> read_data_valid pulse at accept+2 with 0xDEADBEEF.
- Streaming reads: write 0..7 with data=addr*3. Then issue 8 consecutive reads 0..7 -> 8 consecutive valid cycles starting at accept+2, data 0,3,...,21 in order.
- Same-cycle collision: read and write addr 0x10 together, write_data 0x1234, prior content 0xAAAA -> read returns 0x1234. Then repeat with write on the cycle after the read -> read returns the prior content.
- Aliasing: write addr 0x00000405 data 0x77 (DEPTH_LOG2=10) -> read addr 0x5 returns 0x77.
- Reset mid-flight: issue a read, assert rst_n low the next cycle for 1 cycle -> read_data_valid, write_ack and read_data all 0, and no response ever emerges.
- Latency sweep: READ_LATENCY=1 and 8, repeat the streaming test -> first valid at accept+1 and accept+8 respectively, data in order.
